demux3_reg: RTL and testbench

//  Registered 1-to-3 steering demux: the inverse of the 3-input select mux.

---
 rtl/demux3_reg.sv | 121 ++++++++++++
 tb/tb_demux3_reg.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux3_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux3_reg
// Purpose  : Registered 1-to-3 steering demux with a valid/ready handshake,
//            a single-entry output register and a saturating drop counter.
// Revision : 1.0  initial release
// ============================================================================
module demux3_reg #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [1:0]            in_select,
   output logic [2:0]            out_valid,
   input  logic [2:0]            out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  drop_count
);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   localparam logic [1:0] c_SEL_DROP = 2'b11;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [1:0]              r_dest;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [CNT_WIDTH-1:0]    r_cnt;

   logic                    w_q_ready;
   logic                    w_in_ready;
   logic [2:0]              w_out_valid;
   logic                    w_sel_drop;
   logic                    w_load;
   logic                    w_drop;

   // Only the ready of the currently addressed sink can release the word.
   always_comb begin
      w_q_ready = 1'b0;
      case (r_dest)
         2'd0:    w_q_ready = out_ready[0];
         2'd1:    w_q_ready = out_ready[1];
         2'd2:    w_q_ready = out_ready[2];
         default: w_q_ready = 1'b0;
      endcase
   end

   assign w_sel_drop = (in_select == c_SEL_DROP);

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 3'b000;
      case (r_state)
         S_EMPTY: begin
            w_in_ready = 1'b1;
            if (in_valid && !w_sel_drop) begin
               w_state_nxt = S_FULL;
            end
         end
         S_FULL: begin
            w_in_ready = w_q_ready;
            case (r_dest)
               2'd0:    w_out_valid = 3'b001;
               2'd1:    w_out_valid = 3'b010;
               2'd2:    w_out_valid = 3'b100;
               default: w_out_valid = 3'b000;
            endcase
            if (w_q_ready && !(in_valid && !w_sel_drop)) begin
               w_state_nxt = S_EMPTY;
            end
         end
         default: begin
            w_state_nxt = S_EMPTY;
         end
      endcase
   end

   assign w_load = in_valid && w_in_ready && !w_sel_drop;
   assign w_drop = in_valid && w_in_ready && w_sel_drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_dest <= 2'd0;
      end else if (w_load) begin
         r_data <= in_data;
         r_dest <= in_select;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_drop && (r_cnt != {CNT_WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = w_out_valid;
   assign out_data   = r_data;
   assign drop_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux3_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux3_reg
// Purpose  : Self-checking bench for demux3_reg (directed + randomized).
// Revision : 1.0  initial release
// ============================================================================
module tb_demux3_reg;

   localparam int DW   = 32;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [1:0]    in_select;
   logic [2:0]    out_valid;
   logic [2:0]    out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] drop_count;

   int checks = 0;
   int errors = 0;

   // Reference model: the held word (if any) and the drop tally.
   int            m_dest;
   logic [DW-1:0] m_data;
   int            m_cnt;

   demux3_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_select  (in_select),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .drop_count (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic m_ready();
      return (m_dest < 0) || out_ready[m_dest];
   endfunction

   function automatic logic [2:0] m_valid();
      return (m_dest < 0) ? 3'b000 : 3'(1 << m_dest);
   endfunction

   // Advance the model with the current inputs, then clock the DUT.
   task automatic tick();
      if (in_valid && m_ready()) begin
         if (in_select == 2'b11) begin
            m_dest = -1;
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
         end else begin
            m_dest = int'(in_select);
            m_data = in_data;
         end
      end else if (m_dest >= 0 && out_ready[m_dest]) begin
         m_dest = -1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_select = 2'b00;
      out_ready = 3'b000;
      m_dest    = -1;
      m_data    = '0;
      m_cnt     = 0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (out_valid !== 3'b000 || drop_count !== '0 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_state: out_valid=%b drop=%0d data=%h expected 000/0/0",
                  out_valid, drop_count, out_data);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      // Build up a drop and a held word, then reset asynchronously mid-cycle.
      in_valid = 1'b1; in_select = 2'b11; in_data = 32'h1111_1111;
      tick();
      in_select = 2'b00; in_data = 32'h2222_2222;
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 3'b001 || drop_count !== 2'd1) begin
         errors++;
         $display("FAIL reset_setup: out_valid=%b drop=%0d expected 001/1", out_valid, drop_count);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 3'b000 || drop_count !== '0) begin
         errors++;
         $display("FAIL reset_async: out_valid=%b drop=%0d expected 000/0", out_valid, drop_count);
      end
      apply_reset();
   endtask

   task automatic test_single_route();
      out_ready = 3'b111;
      in_valid = 1'b1; in_select = 2'b01; in_data = 32'hDEAD_BEEF;
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 3'b010 || out_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL single_route: out_valid=%b data=%h expected 010/deadbeef", out_valid, out_data);
      end
      tick();
      checks++;
      if (out_valid !== 3'b000 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_empty: out_valid=%b in_ready=%b expected 000/1", out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 3'b000;
      in_valid = 1'b1; in_select = 2'b10; in_data = 32'hA5A5_0001;
      tick();
      // Competing word with a different select must not be taken.
      in_select = 2'b00; in_data = 32'h0BAD_0BAD;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (out_valid !== 3'b100 || out_data !== 32'hA5A5_0001 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: valid=%b data=%h rdy=%b expected 100/a5a50001/0",
                     i, out_valid, out_data, in_ready);
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 3'b100;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release_rdy: got %b expected 1", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 3'b000) begin
         errors++;
         $display("FAIL backpressure_drain: out_valid=%b expected 000", out_valid);
      end
   endtask

   task automatic test_wrong_port();
      out_ready = 3'b111;
      in_valid = 1'b1; in_select = 2'b00; in_data = 32'h5A5A_C3C3;
      tick();
      in_valid = 1'b0;
      out_ready = 3'b110;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (out_valid !== 3'b001 || out_data !== 32'h5A5A_C3C3 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL wrong_port[%0d]: valid=%b data=%h rdy=%b expected 001/5a5ac3c3/0",
                     i, out_valid, out_data, in_ready);
         end
         tick();
      end
      out_ready = 3'b001;
      tick();
      checks++;
      if (out_valid !== 3'b000) begin
         errors++;
         $display("FAIL wrong_port_drain: out_valid=%b expected 000", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]    sels [4];
      logic [DW-1:0] words[4];
      sels[0] = 2'b00; sels[1] = 2'b01; sels[2] = 2'b10; sels[3] = 2'b00;
      out_ready = 3'b111;
      for (int i = 0; i < 4; i++) words[i] = 32'hC0DE_0000 + DW'(i);
      for (int i = 0; i <= 4; i++) begin
         in_valid = (i < 4);
         if (i < 4) begin
            in_select = sels[i];
            in_data   = words[i];
         end
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready);
         end
         if (i > 0) begin
            checks++;
            if (out_valid !== 3'(1 << sels[i-1]) || out_data !== words[i-1]) begin
               errors++;
               $display("FAIL b2b_out[%0d]: valid=%b data=%h expected %b/%h",
                        i - 1, out_valid, out_data, 3'(1 << sels[i-1]), words[i-1]);
            end
         end
         tick();
      end
   endtask

   task automatic test_drop_saturate();
      apply_reset();
      out_ready = 3'b111;
      in_valid = 1'b1; in_select = 2'b11;
      for (int i = 0; i < 5; i++) begin
         in_data = DW'($urandom);
         tick();
         checks++;
         if (out_valid !== 3'b000 || int'(drop_count) != ((i + 1 < CMAX) ? i + 1 : CMAX)) begin
            errors++;
            $display("FAIL drop_sat[%0d]: valid=%b drop=%0d expected 000/%0d",
                     i, out_valid, drop_count, (i + 1 < CMAX) ? i + 1 : CMAX);
         end
      end
      in_select = 2'b00; in_data = 32'h7777_0000;
      tick();
      out_ready = 3'b001;
      in_select = 2'b11;
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 3'b000 || drop_count !== 2'd3) begin
         errors++;
         $display("FAIL drop_while_full: valid=%b drop=%0d expected 000/3", out_valid, drop_count);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_select = 2'($urandom_range(0, 3));
         in_data   = DW'($urandom);
         out_ready = 3'($urandom_range(0, 7));
         #1;
         checks++;
         if (in_ready !== m_ready() || out_valid !== m_valid() ||
             int'(drop_count) != m_cnt || (m_dest >= 0 && out_data !== m_data)) begin
            errors++;
            $display("FAIL random[%0d]: rdy=%b valid=%b data=%h drop=%0d expected %b/%b/%h/%0d",
                     i, in_ready, out_valid, out_data, drop_count,
                     m_ready(), m_valid(), m_data, m_cnt);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_route();
      test_backpressure();
      test_wrong_port();
      test_back_to_back();
      test_drop_saturate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
